debug_controller: RTL and testbench
===================================

DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL expose port clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL expose port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose port rx_data  input  8  command byte from host link.
REQ-004 SHALL expose port rx_valid  input  1  rx_data valid.
REQ-005 SHALL expose port rx_ready  output  1  controller accepts command; a byte transfers when rx_valid&&rx_ready.
REQ-006 SHALL expose port tx_data  output  8  dump byte to host link.
REQ-007 SHALL expose port tx_valid  output  1  tx_data valid; held stable until accepted.
REQ-008 SHALL expose port tx_ready  input  1  host link accepts; transfer when tx_valid&&tx_ready.
REQ-009 SHALL expose port dp_en  output  1  datapath clock enable (PC, pipeline latches, register file, data memory).
REQ-010 SHALL expose port du_halt  input  1  halt instruction has reached writeback.
REQ-011 SHALL expose port du_if_id  input  64  {instruction, PC+4} of IF/ID latch.
REQ-012 SHALL expose port du_reg  input  1024  register file image, r31 in bits [1023:992].

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STEP, DUMP; rx_ready=1 only in IDLE.
REQ-014 In IDLE, accepted byte 0x63 ('c') SHALL move to RUN, 0x73 ('s') to STEP, 0x64 ('d') to DUMP; any other byte SHALL be consumed and ignored.
REQ-015 dp_en SHALL be a registered output, 1 only in RUN and STEP.
REQ-016 STEP SHALL assert dp_en for exactly one cycle, then enter DUMP.
REQ-017 In RUN, du_halt=1 sampled SHALL deassert dp_en on the next edge and enter DUMP; RUN SHALL not exit otherwise.
REQ-018 If du_halt=1 when 'c' or 's' is accepted, the controller SHALL go directly to DUMP with dp_en kept 0.
REQ-019 A 32-bit cycle counter SHALL increment on every cycle with dp_en=1, wrapping 0xFFFFFFFF->0.
REQ-020 DUMP SHALL latch a snapshot on entry and send it most-significant byte first: cycle counter (4 bytes), then du_if_id (8 bytes).
REQ-021 A byte index counter SHALL advance only on tx handshake; after the last byte accepted, state SHALL return to IDLE with tx_valid=0 on the next cycle.
REQ-022 tx_valid SHALL be 1 throughout DUMP; tx_data SHALL not change while tx_valid&&!tx_ready.
REQ-023 Back-to-back: tx_ready held 1 SHALL yield one byte per cycle, 12-byte dump in 12 cycles.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, dp_en=0, tx_valid=0, tx_data=0x00, cycle counter=0, byte index=0, rx_ready deasserted until first clock edge after release.
REQ-025 Reset asserted mid-RUN or mid-DUMP SHALL abort the operation; no partial dump resumes after release.

Configuration
REQ-026 With DBG_REGDUMP_EN defined, the dump SHALL append du_reg as 128 bytes, r31 first, each register MSB first (dump length 140).
REQ-027 Without DBG_REGDUMP_EN, du_reg SHALL be ignored and dump length SHALL be 12.

Structure
REQ-028 A shared package SHALL hold the state enumeration, command byte constants (0x63, 0x73, 0x64) and dump length constants (12, 140).
REQ-029 Byte serialisation SHALL be a sub-module dbg_byte_serializer (snapshot shift register, index counter, tx handshake); FSM and cycle counter stay in the top.

Verification
REQ-030 Reset then rx 0x73, tx_ready=1 -> dp_en high exactly 1 cycle; dump bytes 00 00 00 01 then du_if_id MSB first; return to IDLE.
REQ-031 rx 0x63, du_halt rises after 50 enabled cycles -> dp_en falls next edge; dump starts with 00 00 00 32.
REQ-032 During DUMP, tx_ready toggled 1/0 each cycle -> tx_data stable while stalled; exactly 12 bytes delivered, none duplicated.
REQ-033 rx 0x41 in IDLE -> byte consumed, state stays IDLE, dp_en=0, no tx_valid.
REQ-034 Counter preloaded near 0xFFFFFFFE, two steps -> second dump reports 00 00 00 00.
REQ-035 reset=0 during byte 5 of dump -> tx_valid=0 immediately; with DBG_REGDUMP_EN, a full dump after release delivers 140 bytes.

Source files
------------

// File: rtl/debug_controller_pkg.sv
// debug_controller_pkg: shared types and constants for the debug controller.
// Contents: FSM state enum, host command bytes, dump lengths, snapshot width.
// Build option: DBG_REGDUMP_EN appends the 128-byte register file image to each dump.
package debug_controller_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STEP, DUMP} state_t;
    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    localparam int DUMP_LEN_BASE = 12;
    localparam int DUMP_LEN_REG = 140;
`ifdef DBG_REGDUMP_EN
    localparam int DUMP_LEN = DUMP_LEN_REG;
`else
    localparam int DUMP_LEN = DUMP_LEN_BASE;
`endif
    localparam int SNAP_W = DUMP_LEN * 8;
endpackage

// File: rtl/debug_controller_if.sv
// debug_controller_if: host link byte streams of the debug controller.
// Signals: rx_data/rx_valid/rx_ready (host -> controller commands),
//          tx_data/tx_valid/tx_ready (controller -> host dump bytes).
// Modports: master = host link side, slave = controller side.
interface debug_controller_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
    modport slave (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/dbg_byte_serializer.sv
// dbg_byte_serializer: shifts a latched snapshot out MSB byte first over a valid/ready link.
// Ports: clk, reset (async active-low), load (latch snapshot and start),
//        snapshot (dump image), tx_ready (in), tx_data/tx_valid (out),
//        done (last byte accepted this cycle).
// Build option: DBG_REGDUMP_EN (via package) sets the dump length.
module dbg_byte_serializer
    import debug_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SNAP_W-1:0] snapshot,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              done
);
    logic [SNAP_W-1:0] sr;
    logic [7:0]        idx;
    logic              fire;

    assign fire    = tx_valid && tx_ready;
    assign done    = fire && (idx == 8'(DUMP_LEN - 1));
    assign tx_data = sr[SNAP_W-1 -: 8];

    // The shift register only moves on a handshake, so tx_data holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr       <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            sr       <= snapshot;
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (fire) begin
            sr       <= sr << 8;
            idx      <= done ? 8'd0 : idx + 8'd1;
            tx_valid <= !done;
        end
    end
endmodule

// File: rtl/debug_controller.sv
// debug_controller: host-driven run/step/dump control of a pipelined datapath.
// Ports: clk, reset (async active-low), bus (host link, slave modport),
//        dp_en (datapath clock enable), du_halt (halt reached writeback),
//        du_if_id ({instr, PC+4} of IF/ID), du_reg (register file, r31 at top).
// Build option: DBG_REGDUMP_EN appends du_reg to the dump (140 bytes instead of 12).
module debug_controller
    import debug_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    debug_controller_if.slave bus,
    output logic              dp_en,
    input  logic              du_halt,
    input  logic [63:0]       du_if_id,
    input  logic [1023:0]     du_reg
);
    state_t            state, next;
    logic [31:0]       cnt, cnt_next;
    logic              rx_ready_q, fire_rx, load, done;
    logic [SNAP_W-1:0] snapshot;

    assign fire_rx    = bus.rx_valid && rx_ready_q;
    assign bus.rx_ready = rx_ready_q;
    // The snapshot must include the increment happening on the DUMP entry edge.
    assign cnt_next   = cnt + {31'd0, dp_en};
    assign load       = (state != DUMP) && (next == DUMP);

`ifdef DBG_REGDUMP_EN
    assign snapshot = {cnt_next, du_if_id, du_reg};
`else
    logic unused_reg;
    assign unused_reg = ^du_reg;
    assign snapshot = {cnt_next, du_if_id};
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE: if (fire_rx)
                      next = (bus.rx_data == CMD_CONT) ? (du_halt ? DUMP : RUN) :
                             (bus.rx_data == CMD_STEP) ? (du_halt ? DUMP : STEP) :
                             (bus.rx_data == CMD_DUMP) ? DUMP : IDLE;
            RUN:  if (du_halt) next = DUMP;
            STEP: next = DUMP;
            DUMP: if (done) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from the next state; rx_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dp_en      <= 1'b0;
            rx_ready_q <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= next;
            dp_en      <= (next == RUN) || (next == STEP);
            rx_ready_q <= (next == IDLE);
            if (dp_en) cnt <= cnt + 32'd1;
        end
    end

    dbg_byte_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .snapshot (snapshot),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .done     (done)
    );
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: directed self-checking bench for debug_controller.
module tb_debug_controller;
`ifdef DBG_REGDUMP_EN
    localparam int LEN = 140;
`else
    localparam int LEN = 12;
`endif
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          du_halt = 1'b0;
    logic [63:0]   if_id = 64'h0123_4567_89AB_CDEF;
    logic [1023:0] du_reg;
    logic          dp_en;
    logic [7:0]    got [0:139];
    int            vectors = 0;
    int            miscompares = 0;
    int            n, cyc;

    debug_controller_if bus();

    debug_controller dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .dp_en    (dp_en),
        .du_halt  (du_halt),
        .du_if_id (if_id),
        .du_reg   (du_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        chk("rx_ready_cmd", {63'd0, bus.rx_ready}, 64'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Drains a dump; toggle=1 alternates ready 1/0 and checks data holds while stalled.
    task automatic collect(input bit toggle, output int nb, output int cy);
        logic [7:0] held;
        bit stalled;
        nb = 0;
        cy = 0;
        stalled = 0;
        held = 8'h00;
        while (bus.tx_valid && cy < 400) begin
            bus.tx_ready = toggle ? (cy % 2 == 0) : 1'b1;
            if (stalled) chk("stall_stable", {56'd0, bus.tx_data}, {56'd0, held});
            stalled = !bus.tx_ready;
            held = bus.tx_data;
            if (bus.tx_ready && nb < 140) begin
                got[nb] = bus.tx_data;
                nb++;
            end
            tick();
            cy++;
        end
        bus.tx_ready = 1'b0;
        chk("dump_ends", {63'd0, bus.tx_valid}, 64'd0);
    endtask

    task automatic check_dump(input logic [31:0] c, input int nb);
        logic [1119:0] e;
        e = {c, if_id, du_reg};
        chk("dump_len", 64'(nb), 64'(LEN));
        for (int i = 0; i < LEN; i++)
            chk("dump_byte", {56'd0, got[i]}, {56'd0, e[1119-8*i -: 8]});
    endtask

    initial begin
        for (int k = 0; k < 32; k++) du_reg[32*k +: 32] = 32'hA500_0000 | 32'(k);
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        chk("rst_dp_en", {63'd0, dp_en}, 64'd0);
        chk("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        chk("rst_tx_data", {56'd0, bus.tx_data}, 64'd0);
        chk("rst_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rx_ready_pre_edge", {63'd0, bus.rx_ready}, 64'd0);
        tick();
        chk("rx_ready_idle", {63'd0, bus.rx_ready}, 64'd1);

        // single step, back-to-back dump
        send_cmd(8'h73);
        chk("step_dp_en_on", {63'd0, dp_en}, 64'd1);
        tick();
        chk("step_dp_en_off", {63'd0, dp_en}, 64'd0);
        chk("step_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
        collect(1'b0, n, cyc);
        chk("b2b_cycles", 64'(cyc), 64'(LEN));
        check_dump(32'd1, n);
        chk("step_back_idle", {63'd0, bus.rx_ready}, 64'd1);

        // run until halt after 50 enabled cycles, stalled dump
        do_reset();
        send_cmd(8'h63);
        repeat (49) tick();
        chk("run_dp_en", {63'd0, dp_en}, 64'd1);
        du_halt = 1'b1;
        tick();
        du_halt = 1'b0;
        chk("halt_dp_en", {63'd0, dp_en}, 64'd0);
        chk("halt_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
        collect(1'b1, n, cyc);
        check_dump(32'd50, n);

        // unknown command ignored
        send_cmd(8'h41);
        chk("bad_dp_en", {63'd0, dp_en}, 64'd0);
        chk("bad_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        chk("bad_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
        tick();
        chk("bad_tx_valid2", {63'd0, bus.tx_valid}, 64'd0);

        // halted step goes straight to dump
        du_halt = 1'b1;
        send_cmd(8'h73);
        du_halt = 1'b0;
        chk("halted_dp_en", {63'd0, dp_en}, 64'd0);
        chk("halted_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
        collect(1'b0, n, cyc);
        check_dump(32'd50, n);

        // counter wrap
        force dut.cnt = 32'hFFFF_FFFE;
        tick();
        release dut.cnt;
        send_cmd(8'h73);
        tick();
        collect(1'b0, n, cyc);
        check_dump(32'hFFFF_FFFF, n);
        send_cmd(8'h73);
        tick();
        collect(1'b0, n, cyc);
        check_dump(32'h0000_0000, n);

        // reset during byte 5 of a dump
        send_cmd(8'h64);
        bus.tx_ready = 1'b1;
        repeat (4) tick();
        bus.tx_ready = 1'b0;
        chk("mid_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        chk("abort_tx_data", {56'd0, bus.tx_data}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("no_resume", {63'd0, bus.tx_valid}, 64'd0);
        send_cmd(8'h64);
        collect(1'b0, n, cyc);
        check_dump(32'd0, n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
